param_strange_counter: RTL and testbench
========================================

// Module: param_strange_counter
// PURPOSE
//  Parametrised next generation of the board-level button/switch counter: DIGITS-digit hex counter,
//  multiplexed onto a common 7-segment display. Adds up/down direction, run/pause, switch load with
//  clamp, programmable modulus, prescaled count rate, debounced buttons and a wrap pulse.
//  Top-level block under the board wrapper, driven by the 50 MHz board clock.
// PARAMETERS
//  DIGITS       4          display digits; counter width CW = 4*DIGITS
//  SW_W         8          switch bus width (SW_W <= CW)
//  MAX_COUNT    16'hFFFF   wrap value (inclusive), must fit in CW bits
//  TICK_DIV     50000000   clk cycles per count step (>= 2)
//  REFRESH_DIV  50000      clk cycles per display digit slot (>= 2)
//  DEB_CYCLES   500000     cycles a synchronised button must be stable before accepted (>= 1)
// PORTS
//  clk    in   1          board clock, all logic on rising edge
//  BTN0   in   1          reset, asynchronous, active-high
//  BTN3   in   1          load: accepted press loads SW into counter
//  BTN2   in   1          run/pause: accepted press toggles run
//  BTN1   in   1          direction level after debounce: 0 = up, 1 = down
//  SW     in   SW_W       load value
//  AN     out  DIGITS     digit enables, active-low, exactly one low at any time
//  SEG    out  8          {dp,g,f,e,d,c,b,a}, active-low
//  WRAP   out  1          one-cycle pulse on wrap in either direction
// BEHAVIOUR
//  Reset (BTN0=1, async): cnt=0, run=0, prescaler=0, digit idx=0, debouncers cleared (all buttons
//   seen released), AN={DIGITS-1{1},0}, SEG=8'hC0 (digit 0 shows "0", dp off), WRAP=0.
//  Buttons: 2-flop sync, then per-button debouncer: accepted level changes only after DEB_CYCLES
//   consecutive equal synced samples. BTN3/BTN2 act on accepted 0->1 edge only (one pulse per press).
//   Action lands DEB_CYCLES+3 cycles after the raw rise; holding a button gives no repeat.
//  Prescaler: counts 0..TICK_DIV-1 every cycle while run=1; tick when at TICK_DIV-1, then returns to 0.
//   Holds its value while run=0.
//  Count step on tick: up: cnt==MAX_COUNT ? 0 : cnt+1; down: cnt==0 ? MAX_COUNT : cnt-1.
//   WRAP=1 in the cycle after the register update that crossed the wrap, registered, 1 cycle wide.
//  Load pulse: cnt <= (zext(SW) > MAX_COUNT) ? MAX_COUNT : zext(SW); prescaler cleared to 0; no WRAP.
//   Load has priority over a same-cycle tick (tick dropped). Load works in run and pause.
//  Run toggle and load in the same cycle: both apply.
//  Direction change takes effect on the next tick; no effect on cnt by itself.
//  Display: refresh counter 0..REFRESH_DIV-1; at terminal value idx advances 0..DIGITS-1 and wraps.
//   AN[idx]=0, all others 1. SEG shows hex nibble cnt[4*idx+3:4*idx], standard patterns 0-F
//   (0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E), dp bit
//   (SEG[7]) driven 0 only on digit 0 while run=1. AN/SEG registered, change together, no glitch
//   state with two digits enabled.
//  Reset mid-operation: everything returns to reset values immediately. After release the first
//   tick needs a full TICK_DIV cycles of run=1.
// TESTING  (sim params: DIGITS=4 SW_W=8 MAX_COUNT=16'h00FF TICK_DIV=4 REFRESH_DIV=2 DEB_CYCLES=2)
//  1 Reset 10 us then release -> cnt=0, AN=4'b1110, SEG=8'hC0, WRAP=0. Display idx cycles every
//    2 clk: AN 1110 -> 1101 -> 1011 -> 0111 -> 1110.
//  2 SW=8'hD8, BTN3 pulse 1 clk -> ignored (debounce). BTN3 held 10 clk -> cnt=16'h00D8 exactly
//    once. Digit0 SEG=8'h80 ('8'), digit1 SEG=8'hA1 ('d').
//  3 BTN2 press, BTN1=0, cnt=16'h00FE -> 00FF after 4 clk, 0000 after 8 clk with one WRAP pulse.
//    dp lit on digit 0 while running.
//  4 BTN1=1 (down) from cnt=0001 -> 0000 then 00FF with WRAP. Press BTN2 again -> cnt frozen
//    over 40 clk, dp off.
//  5 MAX_COUNT=16'h0064, SW=8'hC8 load -> cnt=16'h0064 (clamped). Load on the same cycle as a tick
//    -> cnt=load value, no step, prescaler restarted.
//  6 BTN0 asserted mid-count at 3 clk into a prescaler period -> outputs reset within the same
//    time step (async). After release, run=0 and cnt stays 0.

Source files
------------

// File: rtl/param_strange_counter.sv
// param_strange_counter: DIGITS-digit hex up/down counter with debounced buttons, clamped
// switch load, prescaled stepping, wrap pulse and a multiplexed active-low 7-segment display.
module param_strange_counter #(
   parameter int unsigned         DIGITS      = 4,
   parameter int unsigned         SW_W        = 8,
   parameter logic [4*DIGITS-1:0] MAX_COUNT   = 16'hFFFF,
   parameter int unsigned         TICK_DIV    = 50000000,
   parameter int unsigned         REFRESH_DIV = 50000,
   parameter int unsigned         DEB_CYCLES  = 500000
) (
   input  logic              clk,
   input  logic              BTN0,
   input  logic              BTN3,
   input  logic              BTN2,
   input  logic              BTN1,
   input  logic [SW_W-1:0]   SW,
   output logic [DIGITS-1:0] AN,
   output logic [7:0]        SEG,
   output logic              WRAP
);
   localparam int unsigned CW = 4 * DIGITS;
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned RW = $clog2(REFRESH_DIV);
   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = 7'h40;
         4'h1:    p = 7'h79;
         4'h2:    p = 7'h24;
         4'h3:    p = 7'h30;
         4'h4:    p = 7'h19;
         4'h5:    p = 7'h12;
         4'h6:    p = 7'h02;
         4'h7:    p = 7'h78;
         4'h8:    p = 7'h00;
         4'h9:    p = 7'h10;
         4'hA:    p = 7'h08;
         4'hB:    p = 7'h03;
         4'hC:    p = 7'h46;
         4'hD:    p = 7'h21;
         4'hE:    p = 7'h06;
         4'hF:    p = 7'h0E;
         default: p = 7'h7F;
      endcase
      return p;
   endfunction

   // button bit order: 2 = load (BTN3), 1 = run toggle (BTN2), 0 = direction (BTN1)
   logic [2:0]        btn_s;
   logic [2:0]        sync1_r, sync2_r, acc_r, accd_r;
   logic [DW-1:0]     deb_r [3];
   logic [CW-1:0]     cnt_r, cnt_nxt_s, sw_ext_s;
   logic [PW-1:0]     presc_r, presc_nxt_s;
   logic [RW-1:0]     rc_r, rc_nxt_s;
   logic [IW-1:0]     idx_r, idx_nxt_s;
   logic              run_r, run_nxt_s, wrap_nxt_s;
   logic              load_s, tgl_s, dir_s;
   logic [3:0]        nib_s;
   logic [DIGITS-1:0] an_nxt_s;
   logic [7:0]        seg_nxt_s;

   assign btn_s    = {BTN3, BTN2, BTN1};
   assign sw_ext_s = CW'(SW);
   assign load_s   = acc_r[2] & ~accd_r[2];
   assign tgl_s    = acc_r[1] & ~accd_r[1];
   assign dir_s    = acc_r[0];

   // next-state for counter, prescaler, run flag and display slot; outputs derive from next state
   always_comb begin
      cnt_nxt_s   = cnt_r;
      presc_nxt_s = presc_r;
      wrap_nxt_s  = 1'b0;
      if (load_s) begin
         cnt_nxt_s   = (sw_ext_s > MAX_COUNT) ? MAX_COUNT : sw_ext_s;
         presc_nxt_s = '0;
      end else if (run_r) begin
         if (presc_r == PW'(TICK_DIV - 1)) begin
            presc_nxt_s = '0;
            if (dir_s) begin
               if (cnt_r == '0) begin
                  cnt_nxt_s  = MAX_COUNT;
                  wrap_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r - 1'b1;
               end
            end else begin
               if (cnt_r == MAX_COUNT) begin
                  cnt_nxt_s  = '0;
                  wrap_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + 1'b1;
               end
            end
         end else begin
            presc_nxt_s = presc_r + 1'b1;
         end
      end else begin
         presc_nxt_s = presc_r;
      end

      run_nxt_s = run_r ^ tgl_s;

      if (rc_r == RW'(REFRESH_DIV - 1)) begin
         rc_nxt_s  = '0;
         idx_nxt_s = (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + 1'b1;
      end else begin
         rc_nxt_s  = rc_r + 1'b1;
         idx_nxt_s = idx_r;
      end

      nib_s = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_nxt_s == IW'(i)) begin
            nib_s = cnt_nxt_s[4*i +: 4];
         end else begin
            nib_s = nib_s;
         end
         an_nxt_s[i] = (idx_nxt_s != IW'(i));
      end
      seg_nxt_s = {~(run_nxt_s & (idx_nxt_s == '0)), hex7(nib_s)};
   end

   // all state and registered outputs; BTN0 is the asynchronous board reset
   always_ff @(posedge clk or posedge BTN0) begin
      if (BTN0) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         acc_r   <= 3'b000;
         accd_r  <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            deb_r[i] <= '0;
         end
         cnt_r   <= '0;
         presc_r <= '0;
         run_r   <= 1'b0;
         rc_r    <= '0;
         idx_r   <= '0;
         AN      <= ~DIGITS'(1);
         SEG     <= 8'hC0;
         WRAP    <= 1'b0;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
         accd_r  <= acc_r;
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] != acc_r[i]) begin
               if (deb_r[i] == DW'(DEB_CYCLES - 1)) begin
                  acc_r[i] <= sync2_r[i];
                  deb_r[i] <= '0;
               end else begin
                  deb_r[i] <= deb_r[i] + 1'b1;
               end
            end else begin
               deb_r[i] <= '0;
            end
         end
         cnt_r   <= cnt_nxt_s;
         presc_r <= presc_nxt_s;
         run_r   <= run_nxt_s;
         rc_r    <= rc_nxt_s;
         idx_r   <= idx_nxt_s;
         AN      <= an_nxt_s;
         SEG     <= seg_nxt_s;
         WRAP    <= wrap_nxt_s;
      end
   end
endmodule

// File: tb/tb_param_strange_counter.sv
// Bench for param_strange_counter: two instances (MAX_COUNT FF and 64) against a windowed
// behavioural model compared every cycle, plus hand-computed literal expectations.
module tb_param_strange_counter;
   localparam int DEB = 2, TDIV = 4, RDIV = 2, NDIG = 4;
   localparam int MMAX [2] = '{255, 100};

   logic       clk = 1'b0;
   logic       btn0 = 1'b1, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
   logic [7:0] sw = 8'h00;
   logic [3:0] an_a, an_b;
   logic [7:0] seg_a, seg_b;
   logic       wrap_a, wrap_b;
   int         checks = 0, failures = 0;
   bit         cmp_en = 1'b0;

   always #10 clk = ~clk;

   param_strange_counter #(.DIGITS(4), .SW_W(8), .MAX_COUNT(16'h00FF), .TICK_DIV(TDIV),
                           .REFRESH_DIV(RDIV), .DEB_CYCLES(DEB)) dut_a (
      .clk(clk), .BTN0(btn0), .BTN3(btn3), .BTN2(btn2), .BTN1(btn1), .SW(sw),
      .AN(an_a), .SEG(seg_a), .WRAP(wrap_a));

   param_strange_counter #(.DIGITS(4), .SW_W(8), .MAX_COUNT(16'h0064), .TICK_DIV(TDIV),
                           .REFRESH_DIV(RDIV), .DEB_CYCLES(DEB)) dut_b (
      .clk(clk), .BTN0(btn0), .BTN3(btn3), .BTN2(btn2), .BTN1(btn1), .SW(sw),
      .AN(an_b), .SEG(seg_b), .WRAP(wrap_b));

   // model state: button history windows, accepted levels, counter values per instance
   int m_cyc, m_phase;
   bit m_run, m_pend_load, m_pend_tgl;
   bit m_acc [3];
   bit m_hist [3][16];
   int m_cnt [2];
   bit m_wrap [2];

   function automatic logic [7:0] pat(input int n);
      case (n)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
        12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_phase = 0; m_run = 0; m_pend_load = 0; m_pend_tgl = 0;
      for (int b = 0; b < 3; b++) begin
         m_acc[b] = 0;
         for (int j = 0; j < 16; j++) m_hist[b][j] = 0;
      end
      for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end
   endtask

   task automatic model_step();
      bit ld, tg, dn, tk, v, same;
      bit raw [3];
      ld = m_pend_load; tg = m_pend_tgl; dn = m_acc[0];
      tk = m_run && (m_phase == TDIV - 1) && !ld;
      for (int k = 0; k < 2; k++) begin
         m_wrap[k] = 0;
         if (ld) m_cnt[k] = (int'(sw) > MMAX[k]) ? MMAX[k] : int'(sw);
         else if (tk && !dn) begin
            if (m_cnt[k] == MMAX[k]) begin m_cnt[k] = 0; m_wrap[k] = 1; end
            else m_cnt[k] = m_cnt[k] + 1;
         end else if (tk && dn) begin
            if (m_cnt[k] == 0) begin m_cnt[k] = MMAX[k]; m_wrap[k] = 1; end
            else m_cnt[k] = m_cnt[k] - 1;
         end
      end
      if (ld) m_phase = 0;
      else if (m_run) m_phase = (m_phase + 1) % TDIV;
      if (tg) m_run = !m_run;
      raw[0] = btn1; raw[1] = btn2; raw[2] = btn3;
      m_pend_load = 0; m_pend_tgl = 0;
      for (int b = 0; b < 3; b++) begin
         for (int j = 15; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
         m_hist[b][0] = raw[b];
         // synchroniser adds two samples of latency; accept after DEB equal samples
         v = m_hist[b][2]; same = 1;
         for (int j = 2; j < DEB + 2; j++) if (m_hist[b][j] != v) same = 0;
         if (same && v != m_acc[b]) begin
            m_acc[b] = v;
            if (v && b == 2) m_pend_load = 1;
            if (v && b == 1) m_pend_tgl = 1;
         end
      end
      m_cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge btn0);
         if (btn0) model_reset(); else model_step();
      end
   end

   function automatic logic [3:0] exp_an();
      logic [3:0] a;
      a = 4'b1111;
      a[(m_cyc / RDIV) % NDIG] = 1'b0;
      return a;
   endfunction

   function automatic logic [7:0] exp_seg(input int k);
      int idx;
      logic [7:0] s;
      idx = (m_cyc / RDIV) % NDIG;
      s = pat((m_cnt[k] >> (4 * idx)) & 15);
      if (m_run && idx == 0) s[7] = 1'b0;
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("an_a", an_a, exp_an());
         chk("an_b", an_b, exp_an());
         chk("seg_a", seg_a, exp_seg(0));
         chk("seg_b", seg_b, exp_seg(1));
         chk("wrap_a", wrap_a, m_wrap[0]);
         chk("wrap_b", wrap_b, m_wrap[1]);
      end
   end

   task automatic check_digit(input int inst, input int d, input logic [7:0] exp, input string name);
      logic [3:0] want_an;
      int n;
      want_an = 4'b1111;
      want_an[d] = 1'b0;
      n = 0;
      @(negedge clk);
      while (an_a !== want_an && n < 16) begin @(negedge clk); n++; end
      chk({name, "_an"}, an_a, want_an);
      chk(name, (inst == 0) ? seg_a : seg_b, exp);
   endtask

   task automatic check_dp(input logic exp, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (an_a !== 4'b1110 && n < 16) begin @(negedge clk); n++; end
      chk(name, seg_a[7], exp);
   endtask

   localparam logic [3:0] AN_SEQ [8] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011,
                                          4'b1011, 4'b0111, 4'b0111, 4'b1110};

   initial begin
      int n;
      // 1: reset and display scan
      #10us;
      @(negedge clk); #5 btn0 = 1'b0;
      chk("rst_an", an_a, 4'b1110);
      chk("rst_seg", seg_a, 8'hC0);
      chk("rst_wrap", wrap_a, 1'b0);
      cmp_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("an_scan", an_a, AN_SEQ[i]);
      end

      // 2: short pulse ignored, held press loads once
      sw = 8'hD8;
      @(negedge clk); btn3 = 1'b1;
      @(negedge clk); btn3 = 1'b0;
      repeat (10) @(negedge clk);
      chk("pulse_ignored", m_cnt[0], 0);
      check_digit(0, 0, 8'hC0, "pulse_d0");
      btn3 = 1'b1;
      repeat (10) @(negedge clk);
      btn3 = 1'b0;
      repeat (8) @(negedge clk);
      chk("load_model_a", m_cnt[0], 32'h00D8);
      chk("load_model_b", m_cnt[1], 32'h0064);
      check_digit(0, 0, 8'h80, "load_a_d0");
      check_digit(0, 1, 8'hA1, "load_a_d1");
      check_digit(0, 2, 8'hC0, "load_a_d2");
      check_digit(1, 0, 8'h99, "clamp_b_d0");
      check_digit(1, 1, 8'h82, "clamp_b_d1");

      // 3: run up from FE through FF to 00 with one wrap pulse
      sw = 8'hFE;
      btn3 = 1'b1; repeat (6) @(negedge clk);
      btn3 = 1'b0; repeat (6) @(negedge clk);
      btn2 = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 8) btn2 = 1'b0;
         if (i == 9) chk("up_ff", m_cnt[0], 32'h00FF);
         if (i == 12) chk("up_wrap_pre", wrap_a, 1'b0);
         if (i == 13) chk("up_wrap", wrap_a, 1'b1);
         if (i == 13) chk("up_zero", m_cnt[0], 0);
         if (i == 14) chk("up_wrap_post", wrap_a, 1'b0);
      end
      chk("running", m_run, 1'b1);
      check_dp(1'b0, "dp_run");

      // 4: down from 0001 through 0000 to 00FF with wrap, then pause
      sw = 8'h01;
      btn1 = 1'b1; btn3 = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 8) btn3 = 1'b0;
         if (i == 9) chk("down_zero", m_cnt[0], 0);
         if (i == 12) chk("down_wrap_pre", wrap_a, 1'b0);
         if (i == 13) chk("down_wrap", wrap_a, 1'b1);
         if (i == 13) chk("down_wrap_b", wrap_b, 1'b1);
         if (i == 13) chk("down_ff", m_cnt[0], 32'h00FF);
         if (i == 14) chk("down_wrap_post", wrap_a, 1'b0);
      end
      btn2 = 1'b1; repeat (8) @(negedge clk);
      btn2 = 1'b0; repeat (40) @(negedge clk);
      chk("paused", m_run, 1'b0);
      chk("frozen_a", m_cnt[0], 32'h00FE);
      check_digit(0, 0, 8'h86, "frozen_a_d0");
      check_digit(0, 1, 8'h8E, "frozen_a_d1");
      check_digit(1, 0, 8'hB0, "frozen_b_d0");
      check_digit(1, 1, 8'h82, "frozen_b_d1");
      check_dp(1'b1, "dp_pause");

      // 5: clamp on B, then a load landing on the same edge as a tick
      sw = 8'hC8;
      btn3 = 1'b1; repeat (6) @(negedge clk);
      btn3 = 1'b0; repeat (6) @(negedge clk);
      check_digit(1, 0, 8'h99, "clampc8_b_d0");
      check_digit(1, 1, 8'h82, "clampc8_b_d1");
      check_digit(0, 0, 8'h80, "c8_a_d0");
      check_digit(0, 1, 8'hC6, "c8_a_d1");
      btn2 = 1'b1; repeat (6) @(negedge clk);
      btn2 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(m_run && m_phase == TDIV - 1) && n < 30) begin @(negedge clk); n++; end
      chk("tick_sync_timeout", (n < 30), 1'b1);
      sw = 8'h21; btn3 = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 7) btn3 = 1'b0;
         if (i == 5) chk("coincide_cnt", m_cnt[0], 32'h21);
         if (i == 5) chk("coincide_phase", m_phase, 0);
         if (i == 5) chk("coincide_wrap", wrap_a, 1'b0);
         if (i == 8) chk("coincide_hold", m_cnt[0], 32'h21);
         if (i == 9) chk("coincide_step", m_cnt[0], 32'h20);
      end

      // 6: asynchronous reset mid-period
      n = 0;
      @(negedge clk);
      while (!(m_run && m_phase == 3) && n < 30) begin @(negedge clk); n++; end
      #5 btn0 = 1'b1;
      #1;
      chk("async_an", an_a, 4'b1110);
      chk("async_seg_a", seg_a, 8'hC0);
      chk("async_seg_b", seg_b, 8'hC0);
      chk("async_wrap_a", wrap_a, 1'b0);
      chk("async_wrap_b", wrap_b, 1'b0);
      repeat (3) @(negedge clk);
      #5 btn0 = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_run", m_run, 1'b0);
      check_digit(0, 0, 8'hC0, "post_rst_d0");
      check_digit(0, 1, 8'hC0, "post_rst_d1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
